// File: rtl/irq_src_ctrl_if.sv
// Register-bus interface for irq_src_ctrl: single-cycle strobe plus registered read data.
interface irq_src_ctrl_if;
   localparam int unsigned AddrW = 3;
   localparam int unsigned DataW = 32;

   logic             bus_en;
   logic             bus_we;
   logic [AddrW-1:0] bus_addr;
   logic [DataW-1:0] bus_wdata;
   logic [DataW-1:0] bus_rdata;

   modport master (
      output bus_en,
      output bus_we,
      output bus_addr,
      output bus_wdata,
      input  bus_rdata
   );

   modport slave (
      input  bus_en,
      input  bus_we,
      input  bus_addr,
      input  bus_wdata,
      output bus_rdata
   );
endinterface

// File: rtl/irq_src_ctrl.sv
// irq_src_ctrl: interrupt source controller with pending/enable/edge registers,
// fixed-priority claim/complete handshake and a registered IRQ to the core.
// Optional feature macro: IRQ_SYNC_EN adds a 2-flop synchroniser on every i_src bit.
module irq_src_ctrl #(
   parameter int unsigned NUM_SRC = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] i_src,
   irq_src_ctrl_if.slave      bus,
   output logic               o_irq
);

   localparam int unsigned IdW   = 5;
   localparam int unsigned DataW = 32;
   localparam int unsigned AddrW = 3;

   localparam logic [AddrW-1:0] AddrPending  = AddrW'(0);
   localparam logic [AddrW-1:0] AddrEnable   = AddrW'(1);
   localparam logic [AddrW-1:0] AddrEdge     = AddrW'(2);
   localparam logic [AddrW-1:0] AddrClaim    = AddrW'(3);
   localparam logic [AddrW-1:0] AddrComplete = AddrW'(4);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_SRC-1:0] s_c;
   logic [NUM_SRC-1:0] src_q;
   logic [NUM_SRC-1:0] pend_q, pend_d;
   logic [NUM_SRC-1:0] enable_q;
   logic [NUM_SRC-1:0] edge_q;
   logic [IdW-1:0]     claimed_q;
   logic               irq_d;

   logic               rd_c, wr_c;
   logic [NUM_SRC-1:0] active_c;
   logic [IdW-1:0]     claim_val_c;
   logic               claim_c;
   logic [NUM_SRC-1:0] claim_onehot_c;
   logic [NUM_SRC-1:0] w1c_c;
   logic               complete_c;
   logic [DataW-1:0]   rdata_c;
   logic               unused_wdata_c;

`ifdef IRQ_SYNC_EN
   logic [NUM_SRC-1:0] sync1_q, sync2_q;

   // Two-flop synchroniser for asynchronous interrupt sources.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= i_src;
         sync2_q <= sync1_q;
      end
   end

   assign s_c = sync2_q;
`else
   assign s_c = i_src;
`endif

   assign rd_c           = bus.bus_en & ~bus.bus_we;
   assign wr_c           = bus.bus_en &  bus.bus_we;
   assign active_c       = pend_q & enable_q;
   assign unused_wdata_c = ^bus.bus_wdata;

   // Fixed priority: lowest index wins, reported as id+1 (0 = nothing active).
   always_comb begin
      claim_val_c = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (active_c[i]) claim_val_c = IdW'(i + 1);
      end
   end

   assign claim_c        = rd_c && (bus.bus_addr == AddrClaim) &&
                           (state_q == ST_ASSERT) && (claim_val_c != '0);
   assign claim_onehot_c = claim_c ? (NUM_SRC'(1) << (claim_val_c - IdW'(1))) : '0;
   assign w1c_c          = (wr_c && (bus.bus_addr == AddrPending)) ?
                           bus.bus_wdata[NUM_SRC-1:0] : '0;
   assign complete_c     = wr_c && (bus.bus_addr == AddrComplete) &&
                           (bus.bus_wdata[IdW-1:0] == claimed_q);

   // Level bits mirror the source; edge bits set on a rising edge, which beats W1C and claim-clear.
   assign pend_d = (~edge_q & s_c) |
                   ( edge_q & ((pend_q & ~w1c_c & ~claim_onehot_c) | (s_c & ~src_q)));

   // Source sampling, pending latch and the RW configuration registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_q    <= '0;
         pend_q   <= '0;
         enable_q <= '0;
         edge_q   <= '0;
      end else begin
         src_q  <= s_c;
         pend_q <= pend_d;
         if (wr_c && (bus.bus_addr == AddrEnable)) enable_q <= bus.bus_wdata[NUM_SRC-1:0];
         if (wr_c && (bus.bus_addr == AddrEdge))   edge_q   <= bus.bus_wdata[NUM_SRC-1:0];
      end
   end

   // Remember which source the ISR claimed so COMPLETE can be matched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         claimed_q <= '0;
      end else if (claim_c) begin
         claimed_q <= claim_val_c;
      end
   end

   // FSM state register and registered IRQ output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         o_irq   <= 1'b0;
      end else begin
         state_q <= state_d;
         o_irq   <= irq_d;
      end
   end

   // FSM next state; IRQ is high exactly while in ASSERT.
   always_comb begin
      state_d = state_q;
      irq_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (active_c != '0) state_d = ST_ASSERT;
         end
         ST_ASSERT: begin
            if (claim_c)                 state_d = ST_SERVICE;
            else if (active_c == '0)     state_d = ST_IDLE;
         end
         ST_SERVICE: begin
            if (complete_c) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      irq_d = (state_d == ST_ASSERT);
   end

   // Read data mux; unimplemented bits and registers read as zero.
   always_comb begin
      rdata_c = '0;
      unique case (bus.bus_addr)
         AddrPending: rdata_c = DataW'(pend_q);
         AddrEnable:  rdata_c = DataW'(enable_q);
         AddrEdge:    rdata_c = DataW'(edge_q);
         AddrClaim:   rdata_c = DataW'(claim_val_c);
         default:     rdata_c = '0;
      endcase
   end

   // Registered read data, held until the next read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.bus_rdata <= '0;
      end else if (rd_c) begin
         bus.bus_rdata <= rdata_c;
      end
   end

endmodule

// File: tb/tb_irq_src_ctrl.sv
// Randomized self-checking bench for irq_src_ctrl against a behavioural model.
module tb_irq_src_ctrl;

   localparam int NSRC = 8;
   localparam int MASK = 'hFF;

   logic            clk;
   logic            rst_n;
   logic [NSRC-1:0] i_src;
   logic            o_irq;

   irq_src_ctrl_if bus();

   irq_src_ctrl #(.NUM_SRC(NSRC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .i_src (i_src),
      .bus   (bus.slave),
      .o_irq (o_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Model state: mode 0 = idle, 1 = requesting, 2 = in service.
   int m_pend, m_en, m_edge, m_srcq, m_mode, m_claimed, m_rdata, m_irq;
   int m_sy1, m_sy2;
   int cur_src;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   function automatic int lowest_id(input int v);
      for (int i = 0; i < NSRC; i++) if (v[i]) return i + 1;
      return 0;
   endfunction

   task automatic model_reset();
      m_pend = 0; m_en = 0; m_edge = 0; m_srcq = 0; m_mode = 0;
      m_claimed = 0; m_rdata = 0; m_irq = 0; m_sy1 = 0; m_sy2 = 0;
   endtask

   // One clock: check current outputs, drive inputs, advance the model across the next edge.
   task automatic cyc(input bit en, input bit we, input int addr, input int wd);
      int s, act, cv, w1c, np;
      bit claim, done;
      @(negedge clk);
      check("irq", int'(o_irq), m_irq);
      check("rdata", int'(bus.bus_rdata), m_rdata);
      bus.bus_en    = en;
      bus.bus_we    = we;
      bus.bus_addr  = 3'(addr);
      bus.bus_wdata = 32'(wd);
      i_src         = NSRC'(cur_src);
`ifdef IRQ_SYNC_EN
      s     = m_sy2;
      m_sy2 = m_sy1;
      m_sy1 = cur_src & MASK;
`else
      s = cur_src & MASK;
`endif
      act   = m_pend & m_en;
      cv    = lowest_id(act);
      claim = en && !we && addr == 3 && m_mode == 1 && cv != 0;
      done  = en && we && addr == 4 && m_mode == 2 && (wd & 31) == m_claimed;
      w1c   = (en && we && addr == 0) ? (wd & MASK) : 0;
      if (en && !we) begin
         case (addr)
            0: m_rdata = m_pend;
            1: m_rdata = m_en;
            2: m_rdata = m_edge;
            3: m_rdata = cv;
            default: m_rdata = 0;
         endcase
      end
      np = 0;
      for (int i = 0; i < NSRC; i++) begin
         if (!m_edge[i])                          np[i] = s[i];
         else if (s[i] && !m_srcq[i])             np[i] = 1'b1;
         else if (w1c[i] || (claim && cv == i+1)) np[i] = 1'b0;
         else                                     np[i] = m_pend[i];
      end
      m_pend = np;
      m_srcq = s;
      if (en && we && addr == 1) m_en   = wd & MASK;
      if (en && we && addr == 2) m_edge = wd & MASK;
      case (m_mode)
         0: if (act != 0) m_mode = 1;
         1: if (claim) begin m_mode = 2; m_claimed = cv; end
            else if (act == 0) m_mode = 0;
         default: if (done) m_mode = 0;
      endcase
      m_irq = (m_mode == 1) ? 1 : 0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 0, 0);
   endtask
   task automatic wr(input int addr, input int wd);
      cyc(1'b1, 1'b1, addr, wd);
   endtask
   task automatic rd(input int addr);
      cyc(1'b1, 1'b0, addr, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      check("irq_pre_rst", int'(o_irq), m_irq);
      rst_n      = 1'b0;
      bus.bus_en = 1'b0;
      model_reset();
      #1;
      check("irq_rst", int'(o_irq), m_irq);
      check("rdata_rst", int'(bus.bus_rdata), m_rdata);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      i_src = '0;
      bus.bus_en = 1'b0; bus.bus_we = 1'b0; bus.bus_addr = '0; bus.bus_wdata = '0;
      cur_src = 0;
      model_reset();
      repeat (3) @(negedge clk);
      check("irq_reset", int'(o_irq), 0);
      check("rdata_reset", int'(bus.bus_rdata), 0);
      rst_n = 1'b1;

      // Single edge source: pulse, pending, claim, complete.
      wr(1, 'h01); wr(2, 'h01);
      cur_src = 'h01; idle(1); cur_src = 0;
      idle(3); rd(0); idle(1); rd(3); idle(1); rd(0);
      wr(4, 1); idle(3);

      // Level sources with multiple pending; lower index first.
      wr(2, 'h00); wr(1, 'hFF);
      cur_src = 'h28; idle(3); rd(3); idle(2); wr(4, 4); idle(3);
      cur_src = 'h20; idle(3); rd(3); idle(1); wr(4, 6);
      cur_src = 0; idle(3);

      // Masked pending edge source becomes visible when enabled.
      wr(1, 'h00); wr(2, 'h04);
      cur_src = 'h04; idle(1); cur_src = 0; idle(3);
      wr(1, 'h04); idle(3); rd(3); idle(1); wr(4, 3); idle(2);

      // Level source withdrawn before claim.
      wr(2, 'h00); wr(1, 'hFF);
      cur_src = 'h01; idle(3); cur_src = 0; idle(2); rd(3); idle(2);

      // Edge event coinciding with W1C, then wrong and right COMPLETE.
      wr(1, 'h00); wr(2, 'h02);
      cur_src = 'h02; wr(0, 'h02); cur_src = 0; idle(1); rd(0);
      wr(1, 'h02); idle(2); rd(3); idle(1); wr(4, 5); idle(2); rd(0); wr(4, 2); idle(2);

      // Edge on the claimed source during the claim cycle; masking in service.
      wr(2, 'hFF); wr(1, 'hFF);
      cur_src = 'h01; idle(1); cur_src = 0; idle(2);
      cur_src = 'h01; rd(3); cur_src = 0; wr(1, 'h00); idle(2); rd(0);
      wr(4, 1); wr(1, 'hFF); idle(3);

      // Reset in the middle of service.
      cur_src = 'h10; idle(3); rd(3); idle(1);
      do_reset();
      cur_src = 0; idle(3);

      // Randomized traffic.
      for (int n = 0; n < 4000; n++) begin
         int p;
         p = int'($urandom_range(0, 999));
         if (p < 3) begin
            do_reset();
         end else begin
            if ($urandom_range(0, 99) < 15) cur_src = int'($urandom) & MASK;
            p = int'($urandom_range(0, 99));
            if (p < 20)      rd(3);
            else if (p < 32) wr(4, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : m_claimed);
            else if (p < 35) wr(1, int'($urandom));
            else if (p < 38) wr(2, int'($urandom));
            else if (p < 41) wr(0, int'($urandom));
            else if (p < 55) cyc(1'b1, 1'($urandom), int'($urandom_range(0, 7)), int'($urandom));
            else             idle(1);
         end
      end
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
